// File: rtl/i2s_decoder.sv
`default_nettype none
// ============================================================================
// Module      : i2s_decoder
// Description : I2S receiver. Oversamples BCK/LRCK/SDATA with clk, detects
//               BCK rising edges, frames standard I2S words (one-bit delay)
//               and presents each left/right pair in parallel with a
//               one-cycle valid strobe.
// Revision    : 1.0 - initial release
//
// Optional feature macro: I2S_DECODER_WATCHDOG_EN
//   When defined, a counter of clk cycles since the last BCK rise declares
//   the stream lost at WDOG_CYCLES. The block then drops lock, clears its
//   staging and outputs, and sets the sticky err_o flag. When the macro is
//   undefined, err_o is tied to 0.
//
// Parameters
//   SAMPLE_BITS : output sample width; words are MSB-aligned to it
//   WDOG_CYCLES : BCK-idle clk cycles before the stream is declared lost
// Ports
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   bclk_i    in   I2S bit clock (asynchronous)
//   lrclk_i   in   I2S word select, 0 = left, 1 = right (asynchronous)
//   sdata_i   in   I2S serial data, MSB first (asynchronous)
//   l_chan_o  out  left sample, two's complement
//   r_chan_o  out  right sample, two's complement
//   valid_o   out  one-clk strobe: new pair on l_chan_o/r_chan_o
//   locked_o  out  frame alignment established
//   err_o     out  sticky stream-lost flag
// ============================================================================
module i2s_decoder #(
  parameter int SAMPLE_BITS = 16,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bclk_i,
  input  logic                   lrclk_i,
  input  logic                   sdata_i,
  output logic [SAMPLE_BITS-1:0] l_chan_o,
  output logic [SAMPLE_BITS-1:0] r_chan_o,
  output logic                   valid_o,
  output logic                   locked_o,
  output logic                   err_o
);

  localparam int              CW   = $clog2(SAMPLE_BITS + 1);
  localparam logic [CW-1:0]   FULL = CW'(SAMPLE_BITS);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    SYNC     = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // --------------------------------------------------------------------------
  // Input synchronisers plus BCK history for edge detection
  // --------------------------------------------------------------------------
  logic bclk_meta, bclk_sync, bclk_hist;
  logic lrck_meta, lrck_sync;
  logic sdat_meta, sdat_sync;
  logic bck_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_meta <= 1'b0;
      bclk_sync <= 1'b0;
      bclk_hist <= 1'b0;
      lrck_meta <= 1'b0;
      lrck_sync <= 1'b0;
      sdat_meta <= 1'b0;
      sdat_sync <= 1'b0;
    end else begin
      bclk_meta <= bclk_i;
      bclk_sync <= bclk_meta;
      bclk_hist <= bclk_sync;
      lrck_meta <= lrclk_i;
      lrck_sync <= lrck_meta;
      sdat_meta <= sdata_i;
      sdat_sync <= sdat_meta;
    end
  end

  assign bck_rise = bclk_sync & ~bclk_hist;

  // Capture stage: LRCK and data taken from the same synchroniser stage as
  // the BCK level that produced the rise.
  logic rise_q, lr_q, sd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      lr_q   <= 1'b0;
      sd_q   <= 1'b0;
    end else begin
      rise_q <= bck_rise;
      lr_q   <= lrck_sync;
      sd_q   <= sdat_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Stream-loss watchdog
  // --------------------------------------------------------------------------
  logic wdog_hit;

`ifdef I2S_DECODER_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_cnt;
  logic          err_flag;

  // Fires on the edge where the counter steps onto WDOG_CYCLES; the counter
  // then saturates so the trip happens only once per BCK outage.
  assign wdog_hit = !bck_rise && (wdog_cnt == WW'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      err_flag <= 1'b0;
    end else begin
      if (bck_rise)
        wdog_cnt <= '0;
      else if (wdog_cnt != WW'(WDOG_CYCLES))
        wdog_cnt <= wdog_cnt + WW'(1);
      if (wdog_hit)
        err_flag <= 1'b1;
    end
  end

  assign err_o = err_flag;
`else
  assign wdog_hit = 1'b0;
  assign err_o    = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Word framing and deserialiser
  // --------------------------------------------------------------------------
  logic                   prev_lr, prev_ok;
  logic [SAMPLE_BITS-1:0] shreg, shreg_in, word_aligned;
  logic [CW-1:0]          bit_cnt, cnt_in;
  logic                   lr_change;
  logic                   close_q, close_ch;
  logic [SAMPLE_BITS-1:0] close_word;

  // The rise that sees LRCK change still carries the LSB of the old word,
  // so the closing word includes that bit before alignment. Bits beyond
  // SAMPLE_BITS are dropped; garbage above the valid bits is shifted out.
  always_comb begin
    shreg_in = shreg;
    cnt_in   = bit_cnt;
    if (bit_cnt != FULL) begin
      shreg_in = {shreg[SAMPLE_BITS-2:0], sd_q};
      cnt_in   = bit_cnt + CW'(1);
    end
    word_aligned = shreg_in << (FULL - cnt_in);
  end

  assign lr_change = rise_q && prev_ok && (lr_q != prev_lr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_lr    <= 1'b0;
      prev_ok    <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      close_q    <= 1'b0;
      close_ch   <= 1'b0;
      close_word <= '0;
    end else begin
      close_q <= 1'b0;
      if (wdog_hit) begin
        prev_ok <= 1'b0;
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (rise_q) begin
        prev_lr <= lr_q;
        prev_ok <= 1'b1;
        if (lr_change) begin
          shreg      <= '0;
          bit_cnt    <= '0;
          // Words closing before lock are only used for alignment.
          close_q    <= (state == LOCKED);
          close_ch   <= prev_lr;
          close_word <= word_aligned;
        end else begin
          shreg   <= shreg_in;
          bit_cnt <= cnt_in;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lock state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNLOCKED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNLOCKED: if (lr_change) state_nxt = SYNC;
      SYNC:     if (lr_change) state_nxt = LOCKED;
      LOCKED:   state_nxt = LOCKED;
      default:  state_nxt = UNLOCKED;
    endcase
    if (wdog_hit) state_nxt = UNLOCKED;
  end

  assign locked_o = (state == LOCKED);

  // --------------------------------------------------------------------------
  // Channel pairing and outputs
  // --------------------------------------------------------------------------
  logic [SAMPLE_BITS-1:0] staged;
  logic                   staged_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staged    <= '0;
      staged_ok <= 1'b0;
      l_chan_o  <= '0;
      r_chan_o  <= '0;
      valid_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (wdog_hit) begin
        staged    <= '0;
        staged_ok <= 1'b0;
        l_chan_o  <= '0;
        r_chan_o  <= '0;
      end else if (close_q) begin
        if (!close_ch) begin
          staged    <= close_word;
          staged_ok <= 1'b1;
        end else if (staged_ok) begin
          l_chan_o  <= staged;
          r_chan_o  <= close_word;
          valid_o   <= 1'b1;
          staged_ok <= 1'b0;
        end
        // A right word with nothing staged is an orphan and is dropped.
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_decoder
// Description : Self-checking bench for i2s_decoder. I2S words are described
//               at word level; a reference model derives the expected sample
//               pairs and their arrival cycle into a scoreboard queue, and an
//               independent monitor compares every valid_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_decoder;

  localparam int SB = 16;

  typedef struct {
    logic        ch;
    logic [31:0] val;
    int          n;
  } word_t;

  typedef struct {
    logic [SB-1:0] l;
    logic [SB-1:0] r;
    int            t;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bclk = 1'b0;
  logic          lrclk = 1'b0;
  logic          sdata = 1'b0;
  logic [SB-1:0] l_chan, r_chan;
  logic          valid, locked, err;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  exp_t          q[$];
  exp_t          mon_e;
  int            widx = 0;
  logic [SB-1:0] staged = '0;
  logic          staged_ok = 1'b0;

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_decoder #(.SAMPLE_BITS(SB), .WDOG_CYCLES(1023)) dut (
    .clk      (clk),
    .rst      (rst),
    .bclk_i   (bclk),
    .lrclk_i  (lrclk),
    .sdata_i  (sdata),
    .l_chan_o (l_chan),
    .r_chan_o (r_chan),
    .valid_o  (valid),
    .locked_o (locked),
    .err_o    (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keep the first SB bits of an n-bit word, zero-pad short words on the right.
  function automatic logic [SB-1:0] align(input logic [31:0] v, input int n);
    logic [31:0] x;
    if (n >= SB) x = v >> (n - SB);
    else         x = v << (SB - n);
    return x[SB-1:0];
  endfunction

  // Reference model: after reset the first (possibly partial) word and the
  // alignment word are discarded; from then on a left word is staged and a
  // right word completes a pair only if a left word is staged.
  task automatic model_close(input word_t w, input int t);
    exp_t e;
    if (widx >= 2) begin
      if (!w.ch) begin
        staged    = align(w.val, w.n);
        staged_ok = 1'b1;
      end else if (staged_ok) begin
        e.l = staged;
        e.r = align(w.val, w.n);
        e.t = t;
        q.push_back(e);
        staged_ok = 1'b0;
      end
    end
    widx++;
  endtask

  // One BCK period (8 clk): low phase with LRCK/data set, then the rise.
  // t is the cycle on which valid_o is required if this rise closes a pair.
  task automatic rise(input logic lr, input logic sd, output int t);
    bclk  = 1'b0;
    lrclk = lr;
    sdata = sd;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    t = cyc + 5;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_words(input word_t w[$], input bit close_last);
    int t;
    for (int i = 0; i < w.size(); i++) begin
      int stop;
      stop = (close_last || i < w.size() - 1) ? 1 : w[i].n / 2;
      rise(w[i].ch, (i == 0) ? 1'($urandom) : w[i-1].val[0], t);
      if (i > 0) model_close(w[i-1], t);
      for (int b = w[i].n - 1; b >= stop; b--)
        rise(w[i].ch, w[i].val[b], t);
    end
    if (close_last) begin
      rise(~w[w.size()-1].ch, w[w.size()-1].val[0], t);
      model_close(w[w.size()-1], t);
    end
    bclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frames(output word_t w[$], input logic first_ch, input int nw,
                        input logic [31:0] lv, input logic [31:0] rv, input int n);
    word_t x;
    w.delete();
    for (int i = 0; i < nw; i++) begin
      x.ch  = first_ch ^ 1'(i & 1);
      x.val = x.ch ? rv : lv;
      x.n   = n;
      w.push_back(x);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_l_chan", 32'(l_chan), 0);
    check("rst_r_chan", 32'(r_chan), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
  endtask

  task automatic do_reset();
    bclk = 1'b0;
    rst  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    widx = 0;
    staged_ok = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (20) @(negedge clk);
    check(name, 32'(q.size()), 0);
    q.delete();
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", {l_chan, r_chan}, 32'hFFFF_FFFF);
      end else begin
        mon_e = q.pop_front();
        check("l_chan", 32'(l_chan), 32'(mon_e.l));
        check("r_chan", 32'(r_chan), 32'(mon_e.r));
        check("valid_latency", 32'(cyc), 32'(mon_e.t));
      end
    end
  end

  initial begin
    word_t w[$];
    word_t x;

    // Basic frames, 16-bit words
    do_reset();
    frames(w, 1'b0, 6, 32'h1234, 32'hABCD, 16);
    send_words(w, 1'b1);
    drain("basic_missing_valid");
    check("basic_locked", 32'(locked), 1);

    // Long words truncated to SB bits
    do_reset();
    frames(w, 1'b0, 6, 32'h8000FF, 32'h7FFF01, 24);
    send_words(w, 1'b1);
    drain("long_missing_valid");

    // Short words left-aligned
    do_reset();
    frames(w, 1'b0, 6, 32'h5A, 32'hC3, 8);
    send_words(w, 1'b1);
    drain("short_missing_valid");

    // Orphan right word directly after lock
    do_reset();
    frames(w, 1'b1, 5, 32'h0F0F, 32'hF0F0, 16);
    send_words(w, 1'b1);
    drain("orphan_missing_valid");

    // Reset in the middle of a right word
    do_reset();
    frames(w, 1'b0, 6, 32'h1111, 32'h2222, 16);
    send_words(w, 1'b0);
    drain("midrst_pre_missing_valid");
    bclk = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    widx = 0;
    staged_ok = 1'b0;
    repeat (2) @(negedge clk);
    frames(w, 1'b0, 4, 32'h3333, 32'h4444, 16);
    send_words(w, 1'b1);
    drain("midrst_post_missing_valid");

    // Randomised word lengths, values and starting channel
    for (int s = 0; s < 6; s++) begin
      logic c0;
      int   nw;
      do_reset();
      c0 = 1'($urandom);
      nw = $urandom_range(6, 10);
      w.delete();
      for (int i = 0; i < nw; i++) begin
        x.ch  = c0 ^ 1'(i & 1);
        x.n   = $urandom_range(4, 24);
        x.val = $urandom & ((32'd1 << x.n) - 32'd1);
        w.push_back(x);
      end
      send_words(w, 1'b1);
      drain("rand_missing_valid");
      check("rand_locked", 32'(locked), 1);
    end

`ifdef I2S_DECODER_WATCHDOG_EN
    // Stream loss: BCK stops for about 1100 clk
    do_reset();
    frames(w, 1'b0, 6, 32'h2468, 32'h1357, 16);
    send_words(w, 1'b1);
    drain("wdog_pre_missing_valid");
    repeat (850) @(negedge clk);
    check("wdog_err_before_trip", 32'(err), 0);
    check("wdog_locked_before_trip", 32'(locked), 1);
    repeat (250) @(negedge clk);
    check("wdog_err", 32'(err), 1);
    check("wdog_locked", 32'(locked), 0);
    check("wdog_l_chan", 32'(l_chan), 0);
    check("wdog_r_chan", 32'(r_chan), 0);
    widx = 0;
    staged_ok = 1'b0;
    frames(w, 1'b0, 4, 32'h0101, 32'hFEFE, 16);
    send_words(w, 1'b1);
    drain("wdog_relock_missing_valid");
    check("wdog_relocked", 32'(locked), 1);
    check("wdog_err_sticky", 32'(err), 1);
`else
    check("err_tied_low", 32'(err), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2s_decoder.md
# i2s_decoder

I2S receiver that recovers stereo PCM samples from an external I2S stream, for example the VERA audio output (VAUDIO_BCK/VAUDIO_LRCK/VAUDIO_DATA). It oversamples the three asynchronous pins with the system clock and detects BCK edges. It deserialises each channel word and presents left/right samples as a parallel pair with a one-cycle valid strobe. It sits on the input side of the audio path, mirroring the I2S encoder on the output side, so that received audio can be mixed with the OPM output.

## Interface
- SAMPLE_BITS, 16: output sample width; incoming words are MSB-aligned to this width.
- WDOG_CYCLES, 1023: clk cycles without a BCK rising edge before the stream is declared lost. Used only with the watchdog macro.
- clk  in  1  system clock, 25 MHz.
- rst  in  1  reset; one clock, asynchronous, active-high.
- bclk_i  in  1  I2S bit clock, asynchronous to clk.
- lrclk_i  in  1  I2S word select, asynchronous; 0 = left, 1 = right.
- sdata_i  in  1  I2S serial data, MSB first.
- l_chan_o  out  SAMPLE_BITS  left sample, signed two's complement.
- r_chan_o  out  SAMPLE_BITS  right sample, signed two's complement.
- valid_o  out  1  one-clk pulse: new l/r pair on the outputs.
- locked_o  out  1  frame alignment established.
- err_o  out  1  sticky stream-lost flag. Cleared only by rst.

## Operation
- **Synchronisation:** each input passes through a 2-FF synchroniser, followed by one history FF on BCK. A BCK rise is the synchronised level 1 with the history level 0. On a BCK rise, lrck and sdata are captured from the same synchroniser stage.
- **Word framing (standard I2S, one-bit delay):** a word for channel C is made of the data bits sampled on these BCK rises:
  - first bit: the rise after the one on which LRCK is first sampled equal to C;
  - last bit: the rise on which LRCK is first sampled not equal to C.
  - That last rise shifts in the LSB and then closes the word.
- **Shift register:**
  - The first SAMPLE_BITS bits of a word are kept and any later bits are discarded.
  - A bit counter saturates at SAMPLE_BITS.
  - A short word (n < SAMPLE_BITS bits) is left-aligned with zero LSB padding: value = shreg << (SAMPLE_BITS − n).
- **States:**
  - UNLOCKED (reset state): waits for the first LRCK change and discards the partial word.
  - SYNC: receives one full word; its closing moves to LOCKED.
  - LOCKED: normal operation.
- **Channel pairing:**
  - A closed left word goes to a staging register.
  - A closed right word, with a left word staged since the last pair, updates l_chan_o and r_chan_o together and pulses valid_o.
  - A right word with no staged left is discarded, with no valid_o.
- locked_o = 1 in LOCKED only.
- Outputs hold their last value between pulses.
- **Reset values:** l_chan_o = 0, r_chan_o = 0, valid_o = 0, locked_o = 0, err_o = 0; state UNLOCKED; counters and staging cleared.
- **Reset mid-word:** all partial data is lost, and the block restarts in UNLOCKED.

## Timing
- Pin requirements: BCK high and low phases ≥ 2 clk periods each, so BCK ≤ 6.25 MHz at a 25 MHz clk. LRCK and data are stable around the BCK rise for ≥ 1 clk on each side.
- Latency: valid_o is asserted exactly 4 clk cycles after the clk edge at which the first synchroniser FF first samples the closing BCK rise high.
- valid_o is high for exactly 1 clk.
- At most one valid_o pulse per LRCK period.
- LRCK transitions with no BCK rises between them produce no words.

## Configuration
- Macro: I2S_DECODER_WATCHDOG_EN.
- **Defined:**
  - A counter counts clk cycles since the last BCK rise and clears on every BCK rise.
  - When the counter reaches WDOG_CYCLES: state goes to UNLOCKED, locked_o = 0, the staging register clears, and err_o is set (sticky).
  - l_chan_o and r_chan_o are forced to 0 on the same cycle.
  - Relocking follows the normal UNLOCKED → SYNC → LOCKED path.
- **Undefined:** there is no counter and err_o is tied to 0. A stopped BCK freezes the state and outputs.

## Test plan
- **Basic frames:** reset, then 3 frames at BCK = 3.125 MHz with 16-bit words, L = 0x1234 and R = 0xABCD. Required response:
  - the first partial frame is discarded;
  - locked_o = 1 after the first full word;
  - then exactly one valid_o per frame with l_chan_o = 0x1234 and r_chan_o = 0xABCD;
  - valid_o occurs 4 clk after the closing BCK rise.
- **Long words:** 24-bit words, L = 0x8000FF and R = 0x7FFF01, with SAMPLE_BITS = 16 → l_chan_o = 0x8000, r_chan_o = 0x7FFF.
- **Short words:** 8-bit words, L = 0x5A and R = 0xC3 → l_chan_o = 0x5A00, r_chan_o = 0xC300.
- **Reset mid-stream:**
  - Stimulus: assert rst in the middle of a right word, then release.
  - During reset: all outputs are 0 and locked_o = 0.
  - After release: no valid_o until one full left word and one full right word are received after the relock.
- **Stream loss (I2S_DECODER_WATCHDOG_EN):** stop BCK for 1100 clk. Required response:
  - err_o = 1, locked_o = 0, l_chan_o = r_chan_o = 0, all at cycle WDOG_CYCLES;
  - when BCK restarts, the block relocks, and err_o stays 1 until rst.
- **Orphan right word:** start the stream on a right word after locking → no valid_o until a left word followed by a right word has been received.
